alu_issue_ctrl: RTL
===================

# alu_issue_ctrl

Sequential issue controller that drives the 8-bit signed ALU from the operand side. It accepts register-level instructions over a valid/ready handshake, reads operands from a 4×8 register file, and drives `alu_a`/`alu_b`/`alu_sel` for one cycle. It then captures the ALU result and five flags, writes the result back, and returns it over a second valid/ready handshake. It sits between an instruction source (testbench or sequencer) and the combinational ALU.

## Interface
Parameters:
- none; widths fixed: data 8, opcode 4, register index 2

Ports:
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  controller can accept
- `instr_op`  in  4  ALU_Sel encoding 0000 ADD … 1110 COMP; 1111 = LOADI (no ALU)
- `instr_rd`  in  2  destination register
- `instr_rs1`  in  2  source for A
- `instr_rs2`  in  2  source for B
- `instr_use_imm`  in  1  B operand = `instr_imm` instead of reg[rs2]
- `instr_imm`  in  8  immediate (B operand or LOADI value)
- `alu_a`, `alu_b`  out  8 each  ALU operands
- `alu_sel`  out  4  ALU opcode
- `alu_result`  in  8  ALU result
- `alu_carry`, `alu_ovf`, `alu_zero`, `alu_neg`, `alu_par`  in  1 each  ALU flags
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts result
- `res_data`  out  8  result / loaded value
- `res_flags`  out  5  {carry, ovf, zero, neg, parity}
- `res_illegal`  out  1  instruction rejected, no writeback
- `flags`  out  5  architectural flag register, same packing

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - `instr_ready`=1.
  - On `instr_valid`&`instr_ready`, latch op/rd and the resolved operands: A=reg[rs1]; B=imm if use_imm, else reg[rs2].
- Acceptance outcomes:
  - op=1111 (LOADI): reg[rd]←imm; `res_data`=imm; `res_flags`=`flags` unchanged; `res_illegal`=0 → RESP. `alu_*` untouched.
  - op=0011 (DIV) with B==0: no issue, no writeback; `res_data`=0x00, `res_flags`=00000, `res_illegal`=1 → RESP.
  - Otherwise: `alu_a`/`alu_b`/`alu_sel` ← latched values → ISSUE.
- ISSUE (exactly 1 cycle):
  - ALU outputs settle combinationally.
  - At the cycle's closing edge: capture `alu_result` into reg[rd] and `res_data`; capture the flags into `flags` and `res_flags`; `res_illegal`=0 → RESP.
- RESP:
  - `res_valid`=1; `res_data`/`res_flags`/`res_illegal` stable.
  - On `res_ready`, go to IDLE.
- `alu_a`/`alu_b`/`alu_sel` hold their last issued values outside ISSUE.
- All arithmetic is performed by the ALU; the controller does no math apart from the B==0 compare.
- Register file: 4×8, reset to 0x00. Single write port, used only at LOADI acceptance or at ISSUE capture.

## Timing
- Reset values:
  - state=IDLE; `instr_ready`=1 from the first cycle after reset.
  - `res_valid`=0; `res_data`=0x00; `res_flags`=00000; `res_illegal`=0.
  - `alu_a`=`alu_b`=0x00; `alu_sel`=0000; `flags`=00000; all registers 0x00.
- ALU op accepted at edge N: `alu_*` valid during cycle N+1; capture at edge N+2; `res_valid`=1 from edge N+2.
- LOADI or illegal accepted at edge N: `res_valid`=1 from edge N+1.
- Throughput:
  - `instr_ready`=0 in ISSUE and RESP; `instr_valid` there is ignored, not queued.
  - Best case is one ALU op per 3 cycles, one LOADI per 2 cycles.
- `res_ready` held high on RESP entry: `res_valid` pulses one cycle; IDLE the next cycle.
- Read-after-write: a writeback always completes before the next acceptance, so a dependent instruction sees the new value with no hazard.
- `rst` asserted in any state, including mid-ISSUE: everything returns to reset values next edge. In-flight instruction dropped, no writeback, no `res_valid`.
- rd may equal rs1/rs2: operands are latched at acceptance, so the old value is used.

## Test plan
- Reset → `instr_ready`=1; `res_valid`=0; `alu_sel`=0000; `flags`=00000; all registers read 0x00.
- LOADI r1=0x5D, LOADI r2=0xD6, then ADD rd=3, rs1=1, rs2=2:
  - ISSUE cycle shows `alu_a`=0x5D, `alu_b`=0xD6, `alu_sel`=0000.
  - `res_data`=0x33, zero=0, neg=0, parity=0, `res_valid` two edges after acceptance; reg3=0x33.
- DIV rs2=r0 (0x00) → `res_illegal`=1, `res_data`=0x00, `alu_sel` keeps its previous value, rd unchanged, `res_valid` one edge after acceptance.
- `use_imm`=1, imm=0x01, op=COMP, rs1 holds 0x01 → `alu_b`=0x01, `alu_sel`=1110, `res_data`=0x01.
- Backpressure: `res_ready`=0 for 5 cycles in RESP → `res_valid`, `res_data`, `res_flags` stable; `instr_ready`=0; a concurrent `instr_valid` is not accepted.
- Assert `rst` during ISSUE of ADD → next cycle all outputs at reset values; rd still 0x00; no `res_valid`.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// alu_issue_ctrl : valid/ready issue controller driving an external 8-bit ALU
// Revision 1.0 : initial release
// ============================================================================
module alu_issue_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   output logic       instr_ready,
   input  logic [3:0] instr_op,
   input  logic [1:0] instr_rd,
   input  logic [1:0] instr_rs1,
   input  logic [1:0] instr_rs2,
   input  logic       instr_use_imm,
   input  logic [7:0] instr_imm,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [3:0] alu_sel,
   input  logic [7:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_ovf,
   input  logic       alu_zero,
   input  logic       alu_neg,
   input  logic       alu_par,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [7:0] res_data,
   output logic [4:0] res_flags,
   output logic       res_illegal,
   output logic [4:0] flags
);

   localparam logic [3:0] C_OP_DIV   = 4'b0011;
   localparam logic [3:0] C_OP_LOADI = 4'b1111;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_RESP  = 2'd2
   } state_t;

   state_t     r_state;
   logic [7:0] r_regs [4];
   logic [1:0] r_rd;

   logic [7:0] w_opa;
   logic [7:0] w_opb;
   logic [4:0] w_alu_flags;
   logic       w_accept;

   assign w_opa       = r_regs[instr_rs1];
   assign w_opb       = instr_use_imm ? instr_imm : r_regs[instr_rs2];
   assign w_alu_flags = {alu_carry, alu_ovf, alu_zero, alu_neg, alu_par};
   assign w_accept    = instr_valid && instr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rd        <= 2'd0;
         instr_ready <= 1'b1;
         res_valid   <= 1'b0;
         res_data    <= 8'h00;
         res_flags   <= 5'b00000;
         res_illegal <= 1'b0;
         alu_a       <= 8'h00;
         alu_b       <= 8'h00;
         alu_sel     <= 4'b0000;
         flags       <= 5'b00000;
         for (int i = 0; i < 4; i++) begin
            r_regs[i] <= 8'h00;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  instr_ready <= 1'b0;
                  if (instr_op == C_OP_LOADI) begin
                     r_regs[instr_rd] <= instr_imm;
                     res_data         <= instr_imm;
                     res_flags        <= flags;
                     res_illegal      <= 1'b0;
                     res_valid        <= 1'b1;
                     r_state          <= S_RESP;
                  end else if ((instr_op == C_OP_DIV) && (w_opb == 8'h00)) begin
                     // Divide by zero is refused here so the ALU never sees it
                     res_data    <= 8'h00;
                     res_flags   <= 5'b00000;
                     res_illegal <= 1'b1;
                     res_valid   <= 1'b1;
                     r_state     <= S_RESP;
                  end else begin
                     alu_a   <= w_opa;
                     alu_b   <= w_opb;
                     alu_sel <= instr_op;
                     r_rd    <= instr_rd;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_regs[r_rd] <= alu_result;
               res_data     <= alu_result;
               res_flags    <= w_alu_flags;
               flags        <= w_alu_flags;
               res_illegal  <= 1'b0;
               res_valid    <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (res_ready) begin
                  res_valid   <= 1'b0;
                  instr_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               res_valid   <= 1'b0;
               instr_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
